// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if: IR/flag inputs, memory handshake and datapath controls of the main controller
interface mc_main_ctrl_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       illegal;
  logic       mem_err;
  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, illegal, mem_err
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, illegal, mem_err
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: RV32I multi-cycle main control FSM with memory handshake timeout
module mc_main_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic           clk,
  input logic           sys_rst_n,
  mc_main_ctrl_if.master bus
);
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;
  // per-state control decode and next-state selection
  always_comb begin
    state_d        = state_q;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.result_src = 2'b00;
    bus.illegal    = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
        state_d        = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (bus.opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          default: begin
            bus.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_d       = bus.opcode == 7'b0000011 ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        state_d     = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
        state_d       = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
        state_d       = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        bus.pc_write  = bus.zero;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        state_d       = S_ALUWB;
      end
      default: state_d = S_RESET;
    endcase
  end
  // stall counter: the error pulse restarts the count while the state holds so the access is retried
  always_comb begin
    stall       = bus.mem_req & ~bus.mem_ready;
    bus.mem_err = MEM_TIMEOUT != 0 && stall && cnt_q == CW'(MEM_TIMEOUT - 1);
    cnt_d       = stall && !bus.mem_err ? cnt_q + CW'(1) : '0;
  end
  // state and stall counter registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: scoreboard bench for the main control FSM with directed vectors
module tb_mc_main_ctrl;
  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  typedef struct {
    logic [15:0] v;
    string       name;
  } exp_t;
  exp_t q[$];
  mc_main_ctrl_if bus();
  mc_main_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [15:0] V_RESET = 16'h0000, V_FSTALL = 16'h8088, V_FETCH = 16'h9888,
    V_DECODE = 16'h0140, V_ILL = 16'h0142, V_MEMADR = 16'h0240, V_MEMRD = 16'hA000,
    V_MEMWR = 16'hE000, V_MEMWR_ERR = 16'hE001, V_MEMWB = 16'h0404, V_EXECR = 16'h0220,
    V_EXECI = 16'h0260, V_ALUWB = 16'h0400, V_BEQ0 = 16'h0210, V_BEQ1 = 16'h0A10,
    V_JAL = 16'h0980;
  logic [15:0] act;
  assign act = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                bus.illegal, bus.mem_err};
  // drive one cycle of inputs, record the expected output vector, then advance a clock
  task automatic step(input logic [6:0] op, input logic rdy, input logic z,
                      input logic [15:0] v, input string name);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.zero      = z;
    q.push_back('{v, name});
    @(posedge clk);
    #1;
  endtask
  // monitor: compares every cycle mid-period against the scoreboard head
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  end
  initial begin
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    @(posedge clk);
    #1;
    step(7'b0110011, 1, 0, V_RESET,  "held_reset");
    sys_rst_n = 1'b1;
    step(7'b0110011, 1, 0, V_RESET,  "reset_cycle");
    step(7'b0110011, 1, 0, V_FETCH,  "fetch_after_reset");
    step(7'b0110011, 1, 0, V_DECODE, "r_decode");
    step(7'b0110011, 1, 0, V_EXECR,  "r_execr");
    step(7'b0110011, 1, 0, V_ALUWB,  "r_aluwb");
    step(7'b0010011, 1, 0, V_FETCH,  "i_fetch");
    step(7'b0010011, 1, 0, V_DECODE, "i_decode");
    step(7'b0010011, 1, 0, V_EXECI,  "i_execi");
    step(7'b0010011, 1, 0, V_ALUWB,  "i_aluwb");
    for (int i = 0; i < 3; i++) step(7'b0000011, 0, 0, V_FSTALL, "lw_fetch_stall");
    step(7'b0000011, 1, 0, V_FETCH,  "lw_fetch");
    step(7'b0000011, 1, 0, V_DECODE, "lw_decode");
    step(7'b0000011, 1, 0, V_MEMADR, "lw_memadr");
    for (int i = 0; i < 3; i++) step(7'b0000011, 0, 0, V_MEMRD, "lw_memread_stall");
    step(7'b0000011, 1, 0, V_MEMRD,  "lw_memread");
    step(7'b0000011, 1, 0, V_MEMWB,  "lw_memwb");
    step(7'b1100011, 1, 1, V_FETCH,  "beq1_fetch");
    step(7'b1100011, 1, 1, V_DECODE, "beq1_decode");
    step(7'b1100011, 1, 1, V_BEQ1,   "beq_taken");
    step(7'b1100011, 1, 0, V_FETCH,  "beq0_fetch");
    step(7'b1100011, 1, 0, V_DECODE, "beq0_decode");
    step(7'b1100011, 1, 0, V_BEQ0,   "beq_not_taken");
    step(7'b1101111, 1, 0, V_FETCH,  "jal_fetch");
    step(7'b1101111, 1, 0, V_DECODE, "jal_decode");
    step(7'b1101111, 1, 0, V_JAL,    "jal");
    step(7'b1101111, 1, 0, V_ALUWB,  "jal_aluwb");
    step(7'b1110011, 1, 0, V_FETCH,  "ill_fetch");
    step(7'b1110011, 1, 0, V_ILL,    "ill_decode");
    step(7'b0100011, 1, 0, V_FETCH,  "ill_then_fetch");
    step(7'b0100011, 1, 0, V_DECODE, "sw_decode");
    step(7'b0100011, 1, 0, V_MEMADR, "sw_memadr");
    for (int i = 1; i <= 8; i++)
      step(7'b0100011, 0, 0, i % 4 == 0 ? V_MEMWR_ERR : V_MEMWR, "sw_timeout");
    step(7'b0100011, 1, 0, V_MEMWR,  "sw_complete");
    step(7'b0100011, 1, 0, V_FETCH,  "sw2_fetch");
    step(7'b0100011, 1, 0, V_DECODE, "sw2_decode");
    step(7'b0100011, 1, 0, V_MEMADR, "sw2_memadr");
    step(7'b0100011, 0, 0, V_MEMWR,  "sw2_stall");
    step(7'b0100011, 0, 0, V_MEMWR,  "sw2_stall");
    sys_rst_n = 1'b0;
    step(7'b0100011, 0, 0, V_RESET,  "async_reset_mid_stall");
    step(7'b0100011, 1, 0, V_RESET,  "reset_hold");
    sys_rst_n = 1'b1;
    step(7'b0110011, 1, 0, V_RESET,  "reset_cycle2");
    step(7'b0110011, 1, 0, V_FETCH,  "fetch_after_reset2");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
